// File: rtl/ahbl_to_apb4_mux.sv
// AHB-Lite slave to APB4 master bridge with PSEL decode,
// PSTRB/PPROT generation and a PREADY watchdog.
module ahbl_to_apb4_mux #(
  parameter int W_HADDR  = 32,
  parameter int W_PADDR  = 16,
  parameter int W_DATA   = 32,
  parameter int N_SLAVES = 4,
  parameter int W_SEL    = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ahbls_hready,
  output logic                       ahbls_hready_resp,
  output logic                       ahbls_hresp,
  input  logic [W_HADDR-1:0]         ahbls_haddr,
  input  logic                       ahbls_hwrite,
  input  logic [1:0]                 ahbls_htrans,
  input  logic [2:0]                 ahbls_hsize,
  input  logic [2:0]                 ahbls_hburst,
  input  logic [3:0]                 ahbls_hprot,
  input  logic                       ahbls_hmastlock,
  input  logic [W_DATA-1:0]          ahbls_hwdata,
  output logic [W_DATA-1:0]          ahbls_hrdata,
  input  logic [W_DATA-1:0]          ahbls_hartid,
  input  logic [W_HADDR-1:0]         ahbls_hd_pc,
  output logic [W_PADDR-1:0]         apbm_paddr,
  output logic [N_SLAVES-1:0]        apbm_psel,
  output logic                       apbm_penable,
  output logic                       apbm_pwrite,
  output logic [W_DATA-1:0]          apbm_pwdata,
  output logic [W_DATA/8-1:0]        apbm_pstrb,
  output logic [2:0]                 apbm_pprot,
  input  logic [N_SLAVES-1:0]        apbm_pready,
  input  logic [N_SLAVES-1:0]        apbm_pslverr,
  input  logic [N_SLAVES*W_DATA-1:0] apbm_prdata,
  output logic [W_DATA-1:0]          apbm_phartid,
  output logic [W_HADDR-1:0]         apbm_pd_pc,
  output logic                       timeout_pulse
);

  localparam int W_STRB = W_DATA / 8;
  localparam int W_CNT  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W_CNT-1:0] TO_M1 =
    W_CNT'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WDAT, SETUP, ACCESS, DONE, ERR0, ERR1
  } state_t;

  state_t               state_q, state_d;
  logic [W_PADDR-1:0]   paddr_q, paddr_d;
  logic [W_SEL-1:0]     idx_q, idx_d;
  logic                 bad_q, bad_d;
  logic                 pwrite_q, pwrite_d;
  logic [W_DATA-1:0]    pwdata_q, pwdata_d;
  logic [W_STRB-1:0]    pstrb_q, pstrb_d;
  logic [2:0]           pprot_q, pprot_d;
  logic [W_DATA-1:0]    hartid_q, hartid_d;
  logic [W_HADDR-1:0]   pc_q, pc_d;
  logic [W_DATA-1:0]    hrdata_q, hrdata_d;
  logic [W_CNT-1:0]     cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;

  logic [W_SEL-1:0]     a_idx;
  logic                 a_bad;
  logic [W_STRB-1:0]    a_strb;
  logic                 accept;
  logic [N_SLAVES-1:0]  dec;
  logic                 sel_on;
  logic                 pready_s;
  logic                 pslverr_s;
  logic [W_DATA-1:0]    prdata_s;

  logic unused_ok;
  assign unused_ok = ^{ahbls_hburst, ahbls_hmastlock,
                       ahbls_hprot[3:2], ahbls_htrans[0],
                       ahbls_haddr[W_HADDR-1:W_PADDR+W_SEL]};

  assign a_idx  = ahbls_haddr[W_PADDR +: W_SEL];
  assign a_bad  = ({1'b0, a_idx} >= (W_SEL+1)'(N_SLAVES));
  assign accept = ahbls_hready && ahbls_htrans[1];

  // Write strobes from size and low address bits; reads strobe nothing.
  always_comb begin
    a_strb = '0;
    if (ahbls_hwrite) begin
      unique case (ahbls_hsize)
        3'd0:    a_strb = W_STRB'(4'b0001) << ahbls_haddr[1:0];
        3'd1:    a_strb = W_STRB'(4'b0011) << {ahbls_haddr[1], 1'b0};
        default: a_strb = {W_STRB{1'b1}};
      endcase
    end
  end

  // One-hot decode of the latched index and response mux from that slave.
  always_comb begin
    dec      = '0;
    prdata_s = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      dec[i]   = (idx_q == W_SEL'(i));
      prdata_s = prdata_s |
                 (apbm_prdata[i*W_DATA +: W_DATA] & {W_DATA{dec[i]}});
    end
  end

  assign pready_s  = |(apbm_pready & dec);
  assign pslverr_s = |(apbm_pslverr & dec);

  // Next state, AHB response and datapath register updates.
  always_comb begin
    state_d           = state_q;
    paddr_d           = paddr_q;
    idx_d             = idx_q;
    bad_d             = bad_q;
    pwrite_d          = pwrite_q;
    pwdata_d          = pwdata_q;
    pstrb_d           = pstrb_q;
    pprot_d           = pprot_q;
    hartid_d          = hartid_q;
    pc_d              = pc_q;
    hrdata_d          = hrdata_q;
    cnt_d             = cnt_q;
    tmo_d             = 1'b0;
    sel_on            = 1'b0;
    apbm_penable      = 1'b0;
    ahbls_hready_resp = 1'b0;
    ahbls_hresp       = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERR1: begin
        ahbls_hready_resp = 1'b1;
        ahbls_hresp       = (state_q == ERR1);
        state_d           = IDLE;
        if (accept) begin
          paddr_d  = ahbls_haddr[W_PADDR-1:0];
          idx_d    = a_idx;
          bad_d    = a_bad;
          pwrite_d = ahbls_hwrite;
          pstrb_d  = a_strb;
          pprot_d  = {~ahbls_hprot[0], 1'b1, ahbls_hprot[1]};
          hartid_d = ahbls_hartid;
          pc_d     = ahbls_hd_pc;
          if (ahbls_hwrite) state_d = WDAT;
          else if (a_bad)   state_d = ERR0;
          else              state_d = SETUP;
        end
      end
      WDAT: begin
        pwdata_d = ahbls_hwdata;
        state_d  = bad_q ? ERR0 : SETUP;
      end
      SETUP: begin
        sel_on  = 1'b1;
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        sel_on       = 1'b1;
        apbm_penable = 1'b1;
        if (pready_s) begin
          if (pslverr_s) begin
            state_d = ERR0;
          end else begin
            state_d = DONE;
            if (!pwrite_q) hrdata_d = prdata_s;
          end
        end else begin
          cnt_d = cnt_q + W_CNT'(1);
          if (TIMEOUT != 0 && cnt_q == TO_M1) begin
            state_d = ERR0;
            tmo_d   = 1'b1;
          end
        end
      end
      ERR0: begin
        ahbls_hresp = 1'b1;
        state_d     = ERR1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign apbm_psel     = sel_on ? dec : '0;
  assign apbm_paddr    = paddr_q;
  assign apbm_pwrite   = pwrite_q;
  assign apbm_pwdata   = pwdata_q;
  assign apbm_pstrb    = pstrb_q;
  assign apbm_pprot    = pprot_q;
  assign apbm_phartid  = hartid_q;
  assign apbm_pd_pc    = pc_q;
  assign ahbls_hrdata  = hrdata_q;
  assign timeout_pulse = tmo_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latched transfer attributes, read data and watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      paddr_q  <= '0;
      idx_q    <= '0;
      bad_q    <= 1'b0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
      hartid_q <= '0;
      pc_q     <= '0;
      hrdata_q <= '0;
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      paddr_q  <= paddr_d;
      idx_q    <= idx_d;
      bad_q    <= bad_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      pprot_q  <= pprot_d;
      hartid_q <= hartid_d;
      pc_q     <= pc_d;
      hrdata_q <= hrdata_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule
